// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port arbiter between video fetch and CPU in front of
// one synchronous video RAM. Video has priority, bounded by a grant streak.
//
// Ports:
//   vga_clk, reset_n        clock, synchronous active-low reset
//   vid_page/vid_addr       video page and offset, vid_rd_req level request
//   vid_rd_ack/vid_data     one-cycle ack with registered read data
//   cpu_addr/cpu_wdata      CPU address and write data, cpu_we write flag
//   cpu_req                 CPU level request
//   cpu_ack/cpu_rdata       one-cycle ack with registered read data
//   ram_addr/ram_en/ram_we  RAM command (ram_en one cycle per access)
//   ram_wdata/ram_rdata     RAM write and read data
module vram_arbiter #(
   parameter int RAM_LATENCY    = 1,
   parameter int MAX_VID_STREAK = 4
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   input  logic [12:0] vid_addr,
   input  logic [7:0]  vid_page,
   input  logic        vid_rd_req,
   output logic        vid_rd_ack,
   output logic [7:0]  vid_data,
   input  logic [20:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_req,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic [20:0] ram_addr,
   output logic        ram_en,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [2:0] LAT_LAST   = 3'(RAM_LATENCY);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_VID_STREAK);

   logic [1:0] state;
   logic       owner_cpu;
   logic       we_q;
   logic [2:0] lat_cnt;
   logic [3:0] streak;
   logic       grant_vid;
   logic       grant_cpu;
   logic       ack_busy;

   // The IDLE cycle that shows an ack is not a grant cycle: the requester
   // updates its address on the ack, so the next request is taken one
   // cycle later with the new address.
   always_comb begin
      ack_busy  = vid_rd_ack | cpu_ack;
      grant_vid = 1'b0;
      grant_cpu = 1'b0;
      if (state == S_IDLE && !ack_busy) begin
         if (vid_rd_req && cpu_req) begin
            if (streak == STREAK_MAX)
               grant_cpu = 1'b1;
            else
               grant_vid = 1'b1;
         end else if (vid_rd_req) begin
            grant_vid = 1'b1;
         end else if (cpu_req) begin
            grant_cpu = 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         owner_cpu  <= 1'b0;
         we_q       <= 1'b0;
         lat_cnt    <= 3'd0;
         streak     <= 4'd0;
         vid_rd_ack <= 1'b0;
         vid_data   <= 8'd0;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= 8'd0;
         ram_addr   <= 21'd0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_wdata  <= 8'd0;
      end else begin
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         vid_rd_ack <= 1'b0;
         cpu_ack    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!cpu_req)
                  streak <= 4'd0;
               if (grant_vid) begin
                  owner_cpu <= 1'b0;
                  we_q      <= 1'b0;
                  ram_addr  <= {vid_page, vid_addr};
                  ram_wdata <= 8'd0;
                  ram_en    <= 1'b1;
                  lat_cnt   <= 3'd0;
                  state     <= S_ACCESS;
                  if (cpu_req && streak != STREAK_MAX)
                     streak <= streak + 4'd1;
               end else if (grant_cpu) begin
                  owner_cpu <= 1'b1;
                  we_q      <= cpu_we;
                  ram_addr  <= cpu_addr;
                  ram_wdata <= cpu_wdata;
                  ram_en    <= 1'b1;
                  ram_we    <= cpu_we;
                  lat_cnt   <= 3'd0;
                  streak    <= 4'd0;
                  state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (lat_cnt == LAT_LAST) begin
                  if (!owner_cpu)
                     vid_data <= ram_rdata;
                  else if (!we_q)
                     cpu_rdata <= ram_rdata;
                  lat_cnt <= 3'd0;
                  state   <= S_DONE;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            S_DONE: begin
               if (owner_cpu)
                  cpu_ack <= 1'b1;
               else
                  vid_rd_ack <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: vector table plus hand sequences for vram_arbiter,
// with an ack scoreboard and a RAM_LATENCY=3 instance.
module tb_vram_arbiter;

   localparam int RL = 1;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b0;

   logic [12:0] vid_addr = '0;
   logic [7:0]  vid_page = '0;
   logic        vid_rd_req = 1'b0;
   logic        vid_rd_ack;
   logic [7:0]  vid_data;
   logic [20:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_we = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic [20:0] ram_addr;
   logic        ram_en;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = '0;

   logic [12:0] vid_addr3 = '0;
   logic [7:0]  vid_page3 = '0;
   logic        vid_rd_req3 = 1'b0;
   logic        vid_rd_ack3;
   logic [7:0]  vid_data3;
   logic [20:0] cpu_addr3 = '0;
   logic [7:0]  cpu_wdata3 = '0;
   logic        cpu_we3 = 1'b0;
   logic        cpu_req3 = 1'b0;
   logic        cpu_ack3;
   logic [7:0]  cpu_rdata3;
   logic [20:0] ram_addr3;
   logic        ram_en3;
   logic        ram_we3;
   logic [7:0]  ram_wdata3;
   logic [7:0]  ram_rdata3;
   logic [2:0]  en_pipe3 = 3'b000;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 vga_clk = ~vga_clk;

   vram_arbiter #(.RAM_LATENCY(RL), .MAX_VID_STREAK(4)) u_dut (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .vid_addr(vid_addr), .vid_page(vid_page),
      .vid_rd_req(vid_rd_req), .vid_rd_ack(vid_rd_ack),
      .vid_data(vid_data),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_we(cpu_we), .cpu_req(cpu_req),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   vram_arbiter #(.RAM_LATENCY(3), .MAX_VID_STREAK(4)) u_dut3 (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .vid_addr(vid_addr3), .vid_page(vid_page3),
      .vid_rd_req(vid_rd_req3), .vid_rd_ack(vid_rd_ack3),
      .vid_data(vid_data3),
      .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
      .cpu_we(cpu_we3), .cpu_req(cpu_req3),
      .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
      .ram_addr(ram_addr3), .ram_en(ram_en3), .ram_we(ram_we3),
      .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
   );

   // RAM model, latency 1: data is valid only in the cycle after ram_en.
   bit [7:0] mem  [4096];
   bit       wr_v [4096];

   function automatic logic [7:0] dflt(input logic [20:0] a);
      if (a == 21'h000401)
         return 8'h41;
      return a[7:0] ^ 8'h3C;
   endfunction

   always @(posedge vga_clk) begin
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr[11:0]]  <= ram_wdata;
            wr_v[ram_addr[11:0]] <= 1'b1;
         end
         ram_rdata <= wr_v[ram_addr[11:0]] ?
                      mem[ram_addr[11:0]] : dflt(ram_addr);
      end else begin
         ram_rdata <= 8'hEE;
      end
   end

   // Latency-3 RAM model: 8'h5C only in the one valid cycle.
   always @(posedge vga_clk)
      en_pipe3 <= {en_pipe3[1:0], ram_en3};
   assign ram_rdata3 = en_pipe3[2] ? 8'h5C : 8'h00;

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      tot_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   typedef struct {
      logic       cpu;
      logic       chk;
      logic [7:0] data;
   } sb_t;

   sb_t sbq[$];

   // Scoreboard: every ack pops the oldest expected result.
   always @(negedge vga_clk) begin
      if (reset_n) begin
         if (ram_we)
            check("we_needs_en", ram_en, 1);
         if (vid_rd_ack || cpu_ack) begin
            check("ack_overlap", vid_rd_ack & cpu_ack, 0);
            if (sbq.size() == 0) begin
               tot_cnt++;
               $display("FAIL unexpected_ack: got vid=%0b cpu=%0b want none",
                        vid_rd_ack, cpu_ack);
            end else begin
               sb_t e;
               e = sbq.pop_front();
               check("ack_owner", cpu_ack, e.cpu);
               if (e.chk)
                  check("ack_data", e.cpu ? cpu_rdata : vid_data, e.data);
            end
         end
      end
   end

   typedef struct {
      logic       cpu;
      logic       we;
      logic [20:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int n;
      int en_cnt;
      bit got;
      n = 0;
      en_cnt = 0;
      got = 0;
      @(posedge vga_clk); #1;
      if (v.cpu) begin
         cpu_req   = 1'b1;
         cpu_we    = v.we;
         cpu_addr  = v.addr;
         cpu_wdata = v.wdata;
      end else begin
         vid_rd_req = 1'b1;
         vid_page   = v.addr[20:13];
         vid_addr   = v.addr[12:0];
      end
      sbq.push_back('{v.cpu, !(v.cpu && v.we), v.exp});
      while (n < 20 && !got) begin
         @(posedge vga_clk); #1;
         n++;
         if (n == 1) begin
            cpu_req    = 1'b0;
            vid_rd_req = 1'b0;
            check("ram_addr", ram_addr, v.addr);
            check("ram_we", ram_we, v.cpu & v.we);
            check("ram_wdata", ram_wdata, v.cpu ? v.wdata : 8'h00);
         end
         if (ram_en)
            en_cnt++;
         if (vid_rd_ack || cpu_ack)
            got = 1;
      end
      check("ack_latency", n, RL + 3);
      check("ram_en_cycles", en_cnt, 1);
   endtask

   initial begin
      vec_t vecs[6];
      int n;
      int acks;
      int en_cnt;
      int ack_cyc[2];
      logic [20:0] en_addr[2];

      vecs[0] = '{1'b0, 1'b0, 21'h000401, 8'h00, 8'h41};
      vecs[1] = '{1'b1, 1'b1, 21'h012345, 8'hA5, 8'h00};
      vecs[2] = '{1'b1, 1'b0, 21'h012345, 8'h00, 8'hA5};
      vecs[3] = '{1'b0, 1'b0, 21'h024ABC, 8'h00, 8'h80};
      vecs[4] = '{1'b1, 1'b0, 21'h1FFFFF, 8'h00, 8'hC3};
      vecs[5] = '{1'b0, 1'b0, 21'h1FFFFF, 8'h00, 8'hC3};

      repeat (3) @(posedge vga_clk);
      #1;
      check("reset_outputs",
            {vid_rd_ack, vid_data, cpu_ack, cpu_rdata,
             ram_addr, ram_en, ram_we, ram_wdata}, 0);
      check("reset_outputs3",
            {vid_rd_ack3, vid_data3, cpu_ack3, cpu_rdata3,
             ram_addr3, ram_en3, ram_we3, ram_wdata3}, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
         if (i == 0)
            check("cpu_rdata_quiet", cpu_rdata, 0);
      end

      // Held video request, address updated on the first ack.
      @(posedge vga_clk); #1;
      vid_page   = 8'h00;
      vid_addr   = 13'd1025;
      vid_rd_req = 1'b1;
      sbq.push_back('{1'b0, 1'b1, 8'h41});
      sbq.push_back('{1'b0, 1'b1, 8'h34});
      n = 0; acks = 0; en_cnt = 0;
      ack_cyc[0] = 0; ack_cyc[1] = 0;
      en_addr[0] = '0; en_addr[1] = '0;
      while (n < 40 && acks < 2) begin
         @(posedge vga_clk); #1;
         n++;
         if (ram_en) begin
            if (en_cnt < 2)
               en_addr[en_cnt] = ram_addr;
            en_cnt++;
         end
         if (vid_rd_ack) begin
            ack_cyc[acks] = n;
            acks++;
            if (acks == 1)
               vid_addr = 13'd520;
            else
               vid_rd_req = 1'b0;
         end
      end
      vid_rd_req = 1'b0;
      repeat (8) begin
         @(posedge vga_clk); #1;
         if (ram_en)
            en_cnt++;
      end
      check("held_acks", acks, 2);
      check("held_en_count", en_cnt, 2);
      check("held_addr0", en_addr[0], 21'h000401);
      check("held_addr1", en_addr[1], 21'd520);
      check("held_period", ack_cyc[1] - ack_cyc[0], RL + 4);

      // Contention: expected grant order V,V,V,V,C repeated twice.
      for (int g = 0; g < 10; g++) begin
         if (g % 5 == 4)
            sbq.push_back('{1'b1, 1'b1, 8'h3C});
         else
            sbq.push_back('{1'b0, 1'b1, 8'h39});
      end
      @(posedge vga_clk); #1;
      vid_page   = 8'h00;
      vid_addr   = 13'd5;
      cpu_addr   = 21'h100000;
      cpu_we     = 1'b0;
      vid_rd_req = 1'b1;
      cpu_req    = 1'b1;
      n = 0; acks = 0;
      while (n < 200 && acks < 10) begin
         @(posedge vga_clk); #1;
         n++;
         if (vid_rd_ack || cpu_ack)
            acks++;
      end
      vid_rd_req = 1'b0;
      cpu_req    = 1'b0;
      check("contention_acks", acks, 10);
      repeat (6) @(posedge vga_clk);
      #1;
      check("contention_drained", sbq.size(), 0);

      // Reset pulse during ACCESS aborts the access.
      @(posedge vga_clk); #1;
      vid_page   = 8'h00;
      vid_addr   = 13'd7;
      vid_rd_req = 1'b1;
      @(posedge vga_clk); #1;
      check("abort_en_before", ram_en, 1);
      vid_rd_req = 1'b0;
      reset_n    = 1'b0;
      @(posedge vga_clk); #1;
      reset_n = 1'b1;
      check("abort_en_after", ram_en, 0);
      check("abort_outputs",
            {vid_rd_ack, vid_data, cpu_ack, cpu_rdata}, 0);
      acks = 0;
      repeat (8) begin
         @(posedge vga_clk); #1;
         if (vid_rd_ack || cpu_ack)
            acks++;
      end
      check("abort_no_ack", acks, 0);
      run_vec('{1'b0, 1'b0, 21'h000005, 8'h00, 8'h39});

      // RAM_LATENCY = 3 instance.
      @(posedge vga_clk); #1;
      vid_page3   = 8'h02;
      vid_addr3   = 13'h0010;
      vid_rd_req3 = 1'b1;
      n = 0; en_cnt = 0; acks = 0;
      while (n < 30 && acks == 0) begin
         @(posedge vga_clk); #1;
         n++;
         if (n == 1) begin
            vid_rd_req3 = 1'b0;
            check("rl3_addr", ram_addr3, 21'h004010);
         end
         if (ram_en3)
            en_cnt++;
         if (vid_rd_ack3)
            acks = 1;
      end
      check("rl3_latency", n, 6);
      check("rl3_en_cycles", en_cnt, 1);
      check("rl3_data", vid_data3, 8'h5C);

      repeat (4) @(posedge vga_clk);
      #1;
      check("final_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
